// File: rtl/tick_divider_pkg.sv
// Shared constants and types for the programmable tick divider.
// Latency: n/a (types and elaboration-time helpers only).
// Backpressure: n/a.
//
// Contents:
//   CNT_W_DEF / N_CH_DEF / DEF_DIV_DEF - default geometry and reset divisor
//   ch_idx_w()                          - width of a channel index for N channels
//   ch_flags_t                          - per-channel single-bit state record
//   ch_step_e                           - classification of what a channel does on an edge
package tick_divider_pkg;

    localparam int          CNT_W_DEF   = 28;
    localparam int          N_CH_DEF    = 4;
    localparam int unsigned DEF_DIV_DEF = 262144;
    localparam int          N_CH_MAX    = 16;

    // A single channel still needs a 1-bit index port.
    function automatic int ch_idx_w(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    localparam int CH_W_DEF = ch_idx_w(N_CH_DEF);

    // Single-bit channel state kept together so it resets and updates as one record.
    typedef struct packed {
        logic pend_vld;   // a new divisor is waiting to be applied
        logic tick;       // registered one-cycle pulse
        logic wave;       // registered square wave
    } ch_flags_t;

    // What a channel does on a given edge, in priority order.
    typedef enum logic [2:0] {
        STEP_CLEAR = 3'd0,   // sync_clr: zero counter/wave, apply pending now
        STEP_STOP  = 3'd1,   // div==0: parked, pending applies regardless of en
        STEP_HOLD  = 3'd2,   // en low: freeze everything except tick
        STEP_COUNT = 3'd3,   // normal increment
        STEP_WRAP  = 3'd4    // last count of the period: tick, toggle, maybe reload
    } ch_step_e;

endpackage

// File: rtl/tick_divider_ch.sv
// One divider channel: counter, active divisor, one-deep pending divisor, tick/wave regs.
// Latency: tick/wave registered, high the cycle after the wrap edge; a pending divisor lands on the next wrap.
// Backpressure: pend stays high from write acceptance until the divisor is applied; the top stalls writes meanwhile.
//
// Ports:
//   clk, rst_n      - clock, async active-low reset
//   en, sync_clr    - global count enable and synchronous clear
//   wr_vld, wr_div  - accepted divisor write for this channel
//   pend            - pending divisor outstanding
//   tick, wave      - channel outputs
module tick_divider_ch
    import tick_divider_pkg::*;
#(
    parameter int          CNT_W   = CNT_W_DEF,
    parameter int unsigned DEF_DIV = DEF_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             wr_vld,
    input  logic [CNT_W-1:0] wr_div,
    output logic             pend,
    output logic             tick,
    output logic             wave
);

    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_pend_div;
    ch_flags_t        r_flags;

    logic [CNT_W-1:0] w_nxt_div;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic [CNT_W-1:0] w_nxt_pend_div;
    ch_flags_t        w_nxt_flags;
    ch_step_e         w_step;
    logic             w_last;
    logic             w_apply;
    logic             w_take_wr;

    // Only meaningful when r_div != 0; the STOP step masks the div==0 case.
    assign w_last = (r_cnt == (r_div - CNT_W'(1)));

    // sync_clr beats a stopped channel, which beats en, which beats wrap/count.
    always_comb begin
        if (sync_clr) begin
            w_step = STEP_CLEAR;
        end else if (r_div == '0) begin
            w_step = STEP_STOP;
        end else if (!en) begin
            w_step = STEP_HOLD;
        end else if (w_last) begin
            w_step = STEP_WRAP;
        end else begin
            w_step = STEP_COUNT;
        end
    end

    // The pending divisor is consumed only at a boundary where the period restarts.
    assign w_apply = r_flags.pend_vld &&
                     ((w_step == STEP_CLEAR) || (w_step == STEP_STOP) || (w_step == STEP_WRAP));

    // The top never issues a write while pend is high; the guard keeps the
    // channel self-consistent if that ever changes. Because acceptance needs
    // pend low, a write landing on a wrap edge is never consumed by that wrap.
    assign w_take_wr = wr_vld && !r_flags.pend_vld;

    always_comb begin
        w_nxt_div         = r_div;
        w_nxt_cnt         = r_cnt;
        w_nxt_pend_div    = r_pend_div;
        w_nxt_flags       = r_flags;
        w_nxt_flags.tick  = 1'b0;

        case (w_step)
            STEP_CLEAR: begin
                w_nxt_cnt        = '0;
                w_nxt_flags.wave = 1'b0;
            end
            STEP_STOP: begin
                w_nxt_cnt = '0;
            end
            STEP_HOLD: begin
                w_nxt_cnt = r_cnt;
            end
            STEP_COUNT: begin
                w_nxt_cnt = r_cnt + CNT_W'(1);
            end
            STEP_WRAP: begin
                w_nxt_cnt        = '0;
                w_nxt_flags.tick = 1'b1;
                w_nxt_flags.wave = ~r_flags.wave;
            end
            default: begin
                w_nxt_cnt = '0;
            end
        endcase

        if (w_apply) begin
            w_nxt_div            = r_pend_div;
            w_nxt_flags.pend_vld = 1'b0;
        end

        if (w_take_wr) begin
            w_nxt_pend_div       = wr_div;
            w_nxt_flags.pend_vld = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div      <= CNT_W'(DEF_DIV);
            r_cnt      <= '0;
            r_pend_div <= '0;
            r_flags    <= '0;
        end else begin
            r_div      <= w_nxt_div;
            r_cnt      <= w_nxt_cnt;
            r_pend_div <= w_nxt_pend_div;
            r_flags    <= w_nxt_flags;
        end
    end

    assign pend = r_flags.pend_vld;
    assign tick = r_flags.tick;
    assign wave = r_flags.wave;

endmodule

// File: rtl/tick_divider.sv
// Bank of N_CH programmable clock-enable dividers with per-channel tick pulse and square wave.
// Latency: tick/wave registered (one cycle after the wrap edge); divisor writes take effect at the channel's next wrap.
// Backpressure: cfg_ready drops while the addressed channel already holds a pending divisor; out-of-range writes are always accepted and dropped.
//
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   en                         - global count enable
//   sync_clr                   - synchronous clear of all counters and waves
//   cfg_valid/cfg_ready        - divisor write handshake
//   cfg_ch, cfg_div            - write target channel and divisor
//   tick[N_CH], wave[N_CH]     - per-channel outputs
module tick_divider
    import tick_divider_pkg::*;
#(
    parameter int          CNT_W   = CNT_W_DEF,
    parameter int          N_CH    = N_CH_DEF,
    parameter int unsigned DEF_DIV = DEF_DIV_DEF,
    // Widened by integrators that need to address beyond N_CH (such writes are dropped).
    parameter int          CH_W    = ch_idx_w(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  wave
);

    logic [N_CH-1:0] w_pend;
    logic [N_CH-1:0] w_wr;
    logic            w_sel_pend;
    logic            w_accept;

    // Out-of-range indices match no channel, so they read as "not pending"
    // and the write is accepted with no target.
    always_comb begin
        w_sel_pend = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                w_sel_pend = w_pend[i];
            end
        end
    end

    assign cfg_ready = ~w_sel_pend;
    assign w_accept  = cfg_valid && cfg_ready;

    always_comb begin
        w_wr = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_wr[i] = w_accept && (cfg_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        tick_divider_ch #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en),
            .sync_clr (sync_clr),
            .wr_vld   (w_wr[g]),
            .wr_div   (cfg_div),
            .pend     (w_pend[g]),
            .tick     (tick[g]),
            .wave     (wave[g])
        );
    end

endmodule

// File: tb/tb_tick_divider.sv
// Bench for tick_divider: directed scenarios plus a randomized run against a countdown-based model.
// Latency: n/a.
// Backpressure: n/a.
module tb_tick_divider;

    localparam int NCH  = 4;
    localparam int CW   = 8;
    localparam int DDIV = 4;
    localparam int CHW  = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic            sync_clr;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [CHW-1:0]  cfg_ch;
    logic [CW-1:0]   cfg_div;
    logic [NCH-1:0]  tick;
    logic [NCH-1:0]  wave;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: each channel counts down the enabled edges left in its period.
    int m_div  [NCH];
    int m_left [NCH];
    int m_pdiv [NCH];
    bit m_pvld [NCH];
    bit m_tick [NCH];
    bit m_wave [NCH];

    always #5 clk = ~clk;

    tick_divider #(
        .CNT_W   (CW),
        .N_CH    (NCH),
        .DEF_DIV (DDIV),
        .CH_W    (CHW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sync_clr  (sync_clr),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .tick      (tick),
        .wave      (wave)
    );

    function automatic bit m_ready();
        int c;
        c = int'(cfg_ch);
        if (c < NCH) return !m_pvld[c];
        return 1'b1;
    endfunction

    function automatic logic [NCH-1:0] m_tick_v();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_tick[i];
        return v;
    endfunction

    function automatic logic [NCH-1:0] m_wave_v();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_wave[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_div[i]  = DDIV;
            m_left[i] = DDIV;
            m_pdiv[i] = 0;
            m_pvld[i] = 1'b0;
            m_tick[i] = 1'b0;
            m_wave[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        bit acc;
        int c;
        if (!rst_n) begin
            model_reset();
            return;
        end
        acc = cfg_valid && m_ready();
        c   = int'(cfg_ch);
        for (int i = 0; i < NCH; i++) begin
            bit had_p;
            had_p     = m_pvld[i];
            m_tick[i] = 1'b0;
            if (sync_clr) begin
                if (had_p) begin
                    m_div[i]  = m_pdiv[i];
                    m_pvld[i] = 1'b0;
                end
                m_left[i] = m_div[i];
                m_wave[i] = 1'b0;
            end else if (m_div[i] == 0) begin
                if (had_p) begin
                    m_div[i]  = m_pdiv[i];
                    m_pvld[i] = 1'b0;
                    m_left[i] = m_div[i];
                end
            end else if (en) begin
                m_left[i] = m_left[i] - 1;
                if (m_left[i] == 0) begin
                    m_tick[i] = 1'b1;
                    m_wave[i] = !m_wave[i];
                    if (had_p) begin
                        m_div[i]  = m_pdiv[i];
                        m_pvld[i] = 1'b0;
                    end
                    m_left[i] = m_div[i];
                end
            end
            if (acc && c == i) begin
                m_pdiv[i] = int'(cfg_div);
                m_pvld[i] = 1'b1;
            end
        end
    endtask

    // Called at a negedge: one active edge, model update, back to the next negedge.
    task automatic advance();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_in(input bit e, input bit clr, input bit vld, input int ch, input int dv);
        en        = e;
        sync_clr  = clr;
        cfg_valid = vld;
        cfg_ch    = CHW'(ch);
        cfg_div   = CW'(dv);
    endtask

    task automatic align_clear();
        set_in(1, 1, 0, 0, 0);
        advance();
        sync_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(1, 0, 1, 0, 9);   // write presented during reset must be ignored
        model_reset();
        repeat (3) advance();
        n_tests++; if (tick !== '0) begin n_fail++; $display("FAIL reset_tick: got %h want 0", tick); end
        n_tests++; if (wave !== '0) begin n_fail++; $display("FAIL reset_wave: got %h want 0", wave); end
        n_tests++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cfg_ready); end
        rst_n = 1'b1;
        set_in(1, 0, 0, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            logic [NCH-1:0] et, ew;
            advance();
            et = (k % 4 == 0) ? '1 : '0;
            ew = ((k / 4) % 2 == 1) ? '1 : '0;
            n_tests++; if (tick !== et) begin n_fail++; $display("FAIL post_reset_tick e%0d: got %h want %h", k, tick, et); end
            n_tests++; if (wave !== ew) begin n_fail++; $display("FAIL post_reset_wave e%0d: got %h want %h", k, wave, ew); end
        end
        #1;
        n_tests++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_write_dropped: ready got %b want 1", cfg_ready); end
        #1;
    endtask

    // ch0: div 4 -> 5 (applied at edge 4) -> 3 written mid-period at edge 11, applied at edge 14.
    task automatic test_period_change();
        align_clear();
        for (int e = 1; e <= 21; e++) begin
            bit er, et;
            if (e == 1)       set_in(1, 0, 1, 0, 5);
            else if (e == 11) set_in(1, 0, 1, 0, 3);
            else              set_in(1, 0, 0, 0, 0);
            er = !((e >= 2 && e <= 4) || (e >= 12 && e <= 14));
            et = (e == 4) || (e == 9) || (e == 14) || (e == 17) || (e == 20);
            #1;
            n_tests++; if (cfg_ready !== er) begin n_fail++; $display("FAIL chg_ready e%0d: got %b want %b", e, cfg_ready, er); end
            advance();
            n_tests++; if (tick[0] !== et) begin n_fail++; $display("FAIL chg_tick0 e%0d: got %b want %b", e, tick[0], et); end
            n_tests++; if ({tick, wave} !== {m_tick_v(), m_wave_v()}) begin
                n_fail++; $display("FAIL chg_model e%0d: got %h/%h want %h/%h", e, tick, wave, m_tick_v(), m_wave_v());
            end
        end
    endtask

    // ch1: div 3 from edge 4; write div 2 on the wrap at edge 7 waits for edge 10;
    // a second write held during 8..10 is refused.
    task automatic test_wrap_edge_write();
        align_clear();
        for (int e = 1; e <= 15; e++) begin
            bit er, et;
            if (e == 1)                set_in(1, 0, 1, 1, 3);
            else if (e == 7)           set_in(1, 0, 1, 1, 2);
            else if (e >= 8 && e <= 10) set_in(1, 0, 1, 1, 6);
            else                       set_in(1, 0, 0, 1, 0);
            er = !((e >= 2 && e <= 4) || (e >= 8 && e <= 10));
            et = (e == 4) || (e == 7) || (e == 10) || (e == 12) || (e == 14);
            #1;
            n_tests++; if (cfg_ready !== er) begin n_fail++; $display("FAIL wrapw_ready e%0d: got %b want %b", e, cfg_ready, er); end
            advance();
            n_tests++; if (tick[1] !== et) begin n_fail++; $display("FAIL wrapw_tick1 e%0d: got %b want %b", e, tick[1], et); end
            n_tests++; if ({tick, wave} !== {m_tick_v(), m_wave_v()}) begin
                n_fail++; $display("FAIL wrapw_model e%0d: got %h/%h want %h/%h", e, tick, wave, m_tick_v(), m_wave_v());
            end
        end
    endtask

    // ch2: div 0 applied at edge 4 (last tick), parked; div 1 written at edge 10,
    // applied at 11, ticking from edge 12.
    task automatic test_stop_restart();
        align_clear();
        for (int e = 1; e <= 16; e++) begin
            bit er, et, ew;
            if (e == 1)       set_in(1, 0, 1, 2, 0);
            else if (e == 10) set_in(1, 0, 1, 2, 1);
            else              set_in(1, 0, 0, 2, 0);
            er = !((e >= 2 && e <= 4) || (e == 11));
            et = (e == 4) || (e >= 12);
            if (e < 4)       ew = 1'b0;
            else if (e < 12) ew = 1'b1;
            else             ew = ((e - 12) % 2 == 1);
            #1;
            n_tests++; if (cfg_ready !== er) begin n_fail++; $display("FAIL stop_ready e%0d: got %b want %b", e, cfg_ready, er); end
            advance();
            n_tests++; if (tick[2] !== et) begin n_fail++; $display("FAIL stop_tick2 e%0d: got %b want %b", e, tick[2], et); end
            n_tests++; if (wave[2] !== ew) begin n_fail++; $display("FAIL stop_wave2 e%0d: got %b want %b", e, wave[2], ew); end
        end
    endtask

    task automatic test_en_clr_rst();
        logic [NCH-1:0] held_wave;
        align_clear();
        set_in(1, 0, 0, 0, 0);
        repeat (2) advance();
        held_wave = m_wave_v();
        en = 1'b0;
        for (int e = 0; e < 10; e++) begin
            advance();
            n_tests++; if (tick !== '0) begin n_fail++; $display("FAIL en_low_tick e%0d: got %h want 0", e, tick); end
            n_tests++; if (wave !== held_wave) begin n_fail++; $display("FAIL en_low_wave e%0d: got %h want %h", e, wave, held_wave); end
        end
        en = 1'b1;
        for (int e = 0; e < 7; e++) begin
            advance();
            n_tests++; if ({tick, wave} !== {m_tick_v(), m_wave_v()}) begin
                n_fail++; $display("FAIL en_resume e%0d: got %h/%h want %h/%h", e, tick, wave, m_tick_v(), m_wave_v());
            end
        end
        sync_clr = 1'b1;
        advance();
        sync_clr = 1'b0;
        n_tests++; if ({tick, wave} !== '0) begin n_fail++; $display("FAIL clr_out: got %h/%h want 0/0", tick, wave); end
        repeat (2) advance();
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++; if ({tick, wave} !== '0) begin n_fail++; $display("FAIL async_rst_out: got %h/%h want 0/0", tick, wave); end
        @(negedge clk);
        advance();
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            logic [NCH-1:0] et;
            advance();
            et = (e % 4 == 0) ? '1 : '0;
            n_tests++; if (tick !== et) begin n_fail++; $display("FAIL rst_def_div e%0d: got %h want %h", e, tick, et); end
        end
    endtask

    // Writes to cfg_ch 4..7 (including a div=0 that would park a channel) are swallowed.
    task automatic test_out_of_range();
        for (int e = 1; e <= 12; e++) begin
            logic [NCH-1:0] et;
            if (e <= 4) set_in(1, 0, 1, 3 + e, 0);
            else        set_in(1, 0, 0, 0, 0);
            et = (e % 4 == 0) ? '1 : '0;
            #1;
            n_tests++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL oor_ready e%0d: got %b want 1", e, cfg_ready); end
            advance();
            n_tests++; if (tick !== et) begin n_fail++; $display("FAIL oor_tick e%0d: got %h want %h", e, tick, et); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            set_in(($urandom_range(0, 7) != 0), ($urandom_range(0, 49) == 0),
                   $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 6));
            #1;
            n_tests++; if (cfg_ready !== m_ready()) begin
                n_fail++; $display("FAIL rnd_ready n%0d: got %b want %b", n, cfg_ready, m_ready());
            end
            advance();
            n_tests++; if ({tick, wave} !== {m_tick_v(), m_wave_v()}) begin
                n_fail++; $display("FAIL rnd_out n%0d: got %h/%h want %h/%h", n, tick, wave, m_tick_v(), m_wave_v());
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        test_reset();
        @(negedge clk);
        test_period_change();
        test_wrap_edge_write();
        test_stop_restart();
        test_en_clr_rst();
        test_out_of_range();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tick_divider.md
TICK_DIVIDER -- requirements
Module: tick_divider

Interface
REQ-001 Parameter CNT_W, default 28, width of each channel's divisor and counter.
REQ-002 Parameter N_CH, default 4, number of independent divider channels (1..16).
REQ-003 Parameter DEF_DIV, default 262144, divisor loaded into every channel at reset.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 en  in  1  global count enable; low freezes all counters.
REQ-007 sync_clr  in  1  synchronous clear of all counters and wave outputs.
REQ-008 cfg_valid  in  1  divisor-write request.
REQ-009 cfg_ready  out  1  divisor-write can be accepted.
REQ-010 cfg_ch  in  max(1,clog2(N_CH))  target channel of write.
REQ-011 cfg_div  in  CNT_W  new divisor value.
REQ-012 tick  out  N_CH  per-channel one-cycle pulse, once per divisor period.
REQ-013 wave  out  N_CH  per-channel square wave, toggles on each tick, period 2*div.

Function
REQ-014 Each channel holds an active divisor div, a counter cnt, a pending divisor and a pending flag.
REQ-015 On each clk edge with en=1 and div>=1: if cnt==div-1, cnt wraps to 0, tick[i] is asserted in the following cycle and wave[i] toggles; otherwise cnt increments.
REQ-016 tick and wave are registered outputs; tick is high for exactly one cycle per wrap.
REQ-017 div=1: tick[i] high every enabled cycle; wave[i] toggles every enabled cycle.
REQ-018 div=0: channel stopped; cnt held at 0, tick[i]=0, wave[i] holds its value.
REQ-019 en=0: all cnt hold, all tick=0, wave holds; pending updates stay pending.
REQ-020 A write is accepted on a clk edge with cfg_valid=1 and cfg_ready=1.
REQ-021 cfg_ready is 0 when cfg_ch<N_CH and the addressed channel's pending flag is set; otherwise 1.
REQ-022 An accepted write with cfg_ch>=N_CH is discarded without effect.
REQ-023 An accepted write stores cfg_div as pending and sets the pending flag; the active div is unchanged until the next wrap of that channel.
REQ-024 At a channel's wrap edge with pending set: div<=pending, flag cleared, cnt<=0; the next tick follows after new-div enabled cycles.
REQ-025 A write accepted on the same edge as that channel's wrap becomes pending and applies at the following wrap, not the current one.
REQ-026 A stopped channel (div=0) applies a pending value on the edge after acceptance, independent of en.
REQ-027 sync_clr=1: all cnt<=0, all wave<=0, tick<=0, any pending divisors applied immediately; sync_clr has priority over en and wrap.
REQ-028 With div=2^(k-1), wave[i] has the frequency of clk/2^k, with 50% duty.

Reset
REQ-029 While rst_n=0: cnt=0, div=DEF_DIV, pending flags=0, pending values=0, tick=0, wave=0.
REQ-030 Reset assertion mid-count or mid-write aborts the operation immediately; a write presented during reset is not accepted.
REQ-031 After rst_n rises, with en=1, the first tick appears after DEF_DIV enabled edges.

Structure
REQ-032 Package tick_divider_pkg holds CNT_W and DEF_DIV defaults, the channel-index width constant and the channel-state record typedef.
REQ-033 Sub-module tick_divider_ch implements one channel (counter, divisor, pending, tick/wave regs) and is instantiated N_CH times; the top holds write decode and cfg_ready.

Verification
REQ-034 Reset then en=1 with DEF_DIV=4 -> tick pulses at cycles 4,8,12 after reset release; wave toggles 0->1->0 with period 8 cycles.
REQ-035 ch0 div=5, write cfg_div=3 mid-period -> old period 5 completes, then ticks every 3 cycles; cfg_ready for ch0 low from acceptance to wrap.
REQ-036 Write arriving on ch1's wrap edge -> applied at the following wrap; second write to ch1 while pending -> cfg_ready=0, write held off.
REQ-037 Write div=0 to ch2 -> ch2 tick stays 0 and wave frozen; then write div=1 -> tick every cycle and wave toggling each cycle, starting two edges later.
REQ-038 en dropped for 10 cycles mid-count, sync_clr pulse, then rst_n pulse mid-count -> counts resume without loss, clear zeroes wave/cnt, reset restores DEF_DIV on all channels.
REQ-039 Write with cfg_ch=N_CH (N_CH=4, cfg_ch=4 at 3-bit width) -> accepted, no channel changes.
